// File: rtl/lfsr_pkg.sv
// Shared constants and helpers for the parallel LFSR.
// Holds default taps/seed, the step limit and the width range check.
package lfsr_pkg;

  localparam int STEP_MAX  = 8;
  localparam int WIDTH_MIN = 8;
  localparam int WIDTH_MAX = 64;

  localparam logic [63:0] DEF_TAPS = 64'h0000_0000_088C_8892;
  localparam logic [63:0] DEF_SEED = 64'h0000_0000_00BD_43C4;

  function automatic bit width_ok(input int w);
    return (w >= WIDTH_MIN) && (w <= WIDTH_MAX);
  endfunction

endpackage

// File: rtl/lfsr_par_step.sv
// One combinational LFSR substep.
// Feedback is the parity of the tapped bits, shifted in at bit 0.
module lfsr_par_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] state,
  input  logic [WIDTH-1:0] taps,
  output logic [WIDTH-1:0] nxt,
  output logic             fb
);

  // parity of tapped bits feeds the new LSB
  always_comb begin
    fb  = ^(state & taps);
    nxt = {state[WIDTH-2:0], fb};
  end

endmodule

// File: rtl/lfsr_par.sv
// Parallel LFSR advancing STEP shifts per enabled cycle.
// Optional LFSR_PAR_LOCKUP_RECOVER_EN replaces all-zero writes with SEED.
module lfsr_par
  import lfsr_pkg::*;
#(
  parameter int               WIDTH = 32,
  parameter logic [WIDTH-1:0] TAPS  = DEF_TAPS[WIDTH-1:0],
  parameter logic [WIDTH-1:0] SEED  = DEF_SEED[WIDTH-1:0],
  parameter int               STEP  = 1
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             en_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] seed_i,
  output logic [WIDTH-1:0] state_o,
  output logic [STEP-1:0]  rnd_o,
  output logic             valid_o,
  output logic             lockup_o
);

  if (!width_ok(WIDTH)) begin : g_bad_width
    $error("lfsr_par: WIDTH out of range");
  end
  if (STEP < 1 || STEP > STEP_MAX) begin : g_bad_step
    $error("lfsr_par: STEP out of range");
  end
  if (SEED == '0) begin : g_bad_seed
    $error("lfsr_par: SEED must be non-zero");
  end

  logic [WIDTH-1:0]         state_q;
  logic [STEP-1:0]          rnd_q;
  logic                     valid_q;
  logic [STEP:0][WIDTH-1:0] chain;
  logic [STEP-1:0]          fb;
  logic                     wr;
  logic                     adv;
  logic                     zero;
  logic [WIDTH-1:0]         wdata;

  assign chain[0] = state_q;

  for (genvar k = 0; k < STEP; k++) begin : g_step
    lfsr_par_step #(.WIDTH(WIDTH)) u_step (
      .state (chain[k]),
      .taps  (TAPS),
      .nxt   (chain[k+1]),
      .fb    (fb[k])
    );
  end

  // select the write value; load wins over advance
  always_comb begin
    wr    = load_i | en_i;
    adv   = en_i & ~load_i;
    wdata = load_i ? seed_i : chain[STEP];
    zero  = wr & (wdata == '0);
`ifdef LFSR_PAR_LOCKUP_RECOVER_EN
    if (zero) wdata = SEED;
`endif
  end

  // state, feedback bits and advance strobe
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= SEED;
      rnd_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      if (wr)  state_q <= wdata;
      if (adv) rnd_q   <= fb;
      valid_q <= adv;
    end
  end

`ifdef LFSR_PAR_LOCKUP_RECOVER_EN
  logic lockup_q;

  // one-cycle flag when an all-zero write was replaced
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) lockup_q <= 1'b0;
    else         lockup_q <= zero;
  end

  assign lockup_o = lockup_q;
`else
  logic unused_zero;
  assign unused_zero = zero;
  assign lockup_o    = 1'b0;
`endif

  assign state_o = state_q;
  assign rnd_o   = rnd_q;
  assign valid_o = valid_q;

endmodule

// File: tb/tb_lfsr_par.sv
// Self-checking bench for lfsr_par against a behavioural model.
// Honours LFSR_PAR_LOCKUP_RECOVER_EN when compiled with it.
module tb_lfsr_par;

  localparam logic [31:0] TP = 32'h088C_8892;
  localparam logic [31:0] SD = 32'h00BD_43C4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        en;
  logic        load;
  logic [31:0] seed;
  logic        en16;

  logic [31:0] s1, s4;
  logic [0:0]  r1;
  logic [3:0]  r4;
  logic        v1, v4, l1, l4;
  logic [15:0] s16;
  logic [0:0]  r16;
  logic        v16, l16;

  int checks = 0;
  int errors = 0;

  lfsr_par #(.STEP(1)) u1 (
    .clk_i(clk), .reset_i(rst), .en_i(en), .load_i(load),
    .seed_i(seed), .state_o(s1), .rnd_o(r1), .valid_o(v1),
    .lockup_o(l1)
  );

  lfsr_par #(.STEP(4)) u4 (
    .clk_i(clk), .reset_i(rst), .en_i(en), .load_i(load),
    .seed_i(seed), .state_o(s4), .rnd_o(r4), .valid_o(v4),
    .lockup_o(l4)
  );

  lfsr_par #(
    .WIDTH(16), .TAPS(16'hB400), .SEED(16'h0001), .STEP(1)
  ) u16 (
    .clk_i(clk), .reset_i(rst), .en_i(en16), .load_i(1'b0),
    .seed_i(16'h0000), .state_o(s16), .rnd_o(r16), .valid_o(v16),
    .lockup_o(l16)
  );

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // n single shifts: feedback = parity of tapped bits, enters at LSB
  function automatic logic [31:0] adv(input logic [31:0] s, input int n,
                                      output logic [3:0] r);
    logic [31:0] x;
    x = s;
    r = '0;
    for (int k = 0; k < n; k++) begin
      r[k] = ($countones(x & TP) % 2) == 1;
      x = (x << 1) | {31'd0, r[k]};
    end
    return x;
  endfunction

  logic [31:0] m1, m4;
  logic [3:0]  mr1, mr4;
  logic        mv1, mv4, ml1, ml4;

  // reference model of both 32-bit instances
  always @(posedge clk or posedge rst) begin
    logic [31:0] n1, n4;
    logic [3:0]  t1, t4;
    logic        z1, z4;
    if (rst) begin
      m1 <= SD; m4 <= SD;
      mr1 <= '0; mr4 <= '0;
      mv1 <= 0; mv4 <= 0; ml1 <= 0; ml4 <= 0;
    end else begin
      t1 = '0; t4 = '0;
      n1 = m1; n4 = m4;
      if (load) begin
        n1 = seed; n4 = seed;
      end else if (en) begin
        n1 = adv(m1, 1, t1);
        n4 = adv(m4, 4, t4);
      end
      z1 = 0; z4 = 0;
`ifdef LFSR_PAR_LOCKUP_RECOVER_EN
      z1 = (load || en) && n1 == 0;
      z4 = (load || en) && n4 == 0;
      if (z1) n1 = SD;
      if (z4) n4 = SD;
`endif
      m1 <= n1; m4 <= n4;
      ml1 <= z1; ml4 <= z4;
      mv1 <= en && !load; mv4 <= en && !load;
      if (en && !load) begin
        mr1 <= t1; mr4 <= t4;
      end
    end
  end

  // compare every cycle on the falling edge
  always @(negedge clk) begin
    chk("state1", 64'(s1), 64'(m1));
    chk("rnd1",   64'(r1), 64'(mr1[0]));
    chk("valid1", 64'(v1), 64'(mv1));
    chk("lock1",  64'(l1), 64'(ml1));
    chk("state4", 64'(s4), 64'(m4));
    chk("rnd4",   64'(r4), 64'(mr4));
    chk("valid4", 64'(v4), 64'(mv4));
    chk("lock4",  64'(l4), 64'(ml4));
  end

  task automatic drive(input logic e, input logic l, input logic [31:0] s);
    @(negedge clk);
    #1;
    en = e; load = l; seed = s;
  endtask

  bit seen [65536];

  initial begin
    logic [3:0]  tr;
    logic [31:0] tv;
    int          cnt;
    bit          dup;

    rst = 1; en = 0; load = 0; seed = 0; en16 = 0;
    repeat (2) @(negedge clk);
    chk("rst_state", 64'(s1), 64'h00BD43C4);
    chk("rst_valid", 64'(v1), 64'h0);
    chk("rst_rnd",   64'(r1), 64'h0);
    tv = adv(SD, 1, tr);
    chk("model_pin", 64'(tv), 64'h017A8788);
    chk("model_fb",  64'(tr[0]), 64'h0);
    #1 rst = 0;

    drive(1, 0, 0);
    drive(0, 0, 0);
    chk("one_state", 64'(s1), 64'h017A8788);
    chk("one_rnd",   64'(r1), 64'h0);
    chk("one_valid", 64'(v1), 64'h1);
    drive(0, 0, 0);
    chk("one_valid_off", 64'(v1), 64'h0);

    drive(1, 1, 32'h12345678);
    drive(1, 0, 0);
    chk("load_state4", 64'(s4), 64'h12345678);
    chk("load_valid4", 64'(v4), 64'h0);
    repeat (5) drive(1, 0, 0);

    drive(0, 1, 0);
    drive(0, 0, 0);
`ifdef LFSR_PAR_LOCKUP_RECOVER_EN
    chk("zero_recover", 64'(s1), 64'h00BD43C4);
    chk("zero_lockup",  64'(l1), 64'h1);
    drive(0, 0, 0);
    chk("zero_lock_off", 64'(l1), 64'h0);
`else
    chk("zero_stored", 64'(s1), 64'h0);
    chk("zero_nolock", 64'(l1), 64'h0);
    repeat (3) drive(1, 0, 0);
    drive(0, 0, 0);
    chk("zero_stuck", 64'(s1), 64'h0);
`endif

    drive(0, 1, SD);
    repeat (6) drive(1, 0, 0);
    @(posedge clk);
    #3 rst = 1;
    #1;
    chk("async_state", 64'(s1), 64'h00BD43C4);
    chk("async_valid", 64'(v1), 64'h0);
    chk("async_state4", 64'(s4), 64'h00BD43C4);
    @(negedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("restart_state", 64'(s1), 64'h017A8788);
    chk("restart_valid", 64'(v1), 64'h1);

    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      #1;
      en   = ($urandom % 4) != 0;
      load = ($urandom % 8) == 0;
      seed = (($urandom % 4) == 0) ? 32'h0 : $urandom;
      rst  = ($urandom % 64) == 0;
    end
    drive(0, 0, 0);
    rst = 0;

    @(negedge clk);
    #1 rst = 1;
    @(negedge clk);
    #1 rst = 0;
    chk("p16_start", 64'(s16), 64'h1);
    seen[1] = 1;
    en16 = 1;
    cnt = 0;
    dup = 0;
    while (cnt < 70000) begin
      @(negedge clk);
      cnt++;
      if (s16 == 16'h1) break;
      if (seen[s16]) dup = 1;
      seen[s16] = 1;
    end
    en16 = 0;
    chk("period", 64'(cnt), 64'd65535);
    chk("no_repeat", 64'(dup), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lfsr_par.md
LFSR_PAR -- requirements
Module: lfsr_par

Interface
REQ-001 Parameter WIDTH, default 32: state register width; legal range 8..64.
REQ-002 Parameter TAPS, default 32'h088C_8892: feedback tap mask. Bit n set means state[n] is XORed into the feedback. The default selects bits 27,23,19,18,15,11,7,4,1.
REQ-003 Parameter SEED, default 32'h00BD_43C4: reset and recovery value; SHALL be non-zero.
REQ-004 Parameter STEP, default 1: single-bit shifts performed per enabled cycle; legal range 1..8.
REQ-005 clk_i  input  1  sole clock; all state changes on its rising edge.
REQ-006 reset_i  input  1  asynchronous, active-high reset.
REQ-007 en_i  input  1  advance the LFSR by STEP shifts this cycle.
REQ-008 load_i  input  1  load seed_i into the state register this cycle.
REQ-009 seed_i  input  WIDTH  value loaded when load_i=1.
REQ-010 state_o  output  WIDTH  current state register contents.
REQ-011 rnd_o  output  STEP  feedback bits generated by the last advance, registered.
REQ-012 valid_o  output  1  high for one cycle after each advance.
REQ-013 lockup_o  output  1  one-cycle pulse on all-zero recovery.

Function
REQ-014 One substep SHALL compute fb = XOR-reduce(state AND TAPS) and set next = {state[WIDTH-2:0], fb}.
REQ-015 With en_i=1 and load_i=0, STEP substeps SHALL chain combinationally in one cycle and the final value SHALL be registered.
REQ-016 rnd_o[k] SHALL be the fb of substep k, k=0 first; rnd_o and valid_o SHALL update at the same edge as the state, i.e. latency 1 cycle from en_i.
REQ-017 With en_i=0 and load_i=0: state and rnd_o SHALL hold; valid_o SHALL be 0.
REQ-018 load_i SHALL have priority over en_i: the state takes seed_i, no shift occurs, valid_o=0 and rnd_o holds.
REQ-019 state_o SHALL be the register output directly, with no combinational path from inputs.
REQ-020 Back-to-back en_i SHALL advance every cycle, with no bubbles.

Reset
REQ-021 While reset_i=1: state=SEED[WIDTH-1:0], rnd_o=0, valid_o=0, lockup_o=0, held regardless of clk_i.
REQ-022 Reset asserted mid-sequence SHALL discard any pending advance or load; the first advance after release starts from SEED.

Configuration
REQ-023 Macro LFSR_PAR_LOCKUP_RECOVER_EN.
- Defined: any register write whose value would be all-zero (load or advance) SHALL write SEED instead and pulse lockup_o for that cycle.
- Undefined: the all-zero value is stored and remains stuck; lockup_o is tied to 0.

Structure
REQ-024 Package lfsr_pkg SHALL hold the default TAPS and SEED constants, STEP_MAX=8, and a WIDTH range-check helper.
REQ-025 Sub-module lfsr_par_step SHALL implement one combinational substep (state, TAPS -> next, fb); lfsr_par instantiates STEP copies in a chain.
REQ-026 Illegal parameter values (SEED=0, STEP or WIDTH out of range) SHALL be rejected at elaboration.

Verification
REQ-027 Reset with defaults -> state_o=0x00BD43C4, valid_o=0, rnd_o=0.
REQ-028 One en_i pulse from reset -> next cycle state_o=0x017A8788, rnd_o[0]=0, valid_o=1; following cycle valid_o=0.
REQ-029 load_i=1, en_i=1, seed_i=0x12345678 -> state_o=0x12345678, valid_o=0; then STEP=4 advances match a 4x single-step reference model.
REQ-030 Macro defined, load seed_i=0 -> state_o=0x00BD43C4, lockup_o=1 for exactly one cycle. Macro undefined -> state_o=0 and stays 0 under en_i.
REQ-031 reset_i asserted asynchronously between edges during continuous en_i -> state_o=SEED immediately; after release the sequence restarts identical to REQ-028.
REQ-032 WIDTH=16, TAPS=16'hB400, SEED=1, STEP=1, 65535 advances -> state returns to 1 with no earlier repeat (maximal period).
